multi_evt_counter: RTL and testbench

//  NUM_CH independent modulo event counters (e.g. one per candidate/ballot class).

---
 rtl/multi_evt_counter.sv | 127 ++++++++++++
 tb/tb_multi_evt_counter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_evt_counter.sv
// NUM_CH independent modulo event counters (wrap or saturate) plus a snapshot
// engine that freezes all counts and streams them out one channel per beat.
module multi_evt_counter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_COUNT = 256,
    parameter int SATURATE  = 0,
    localparam int CW = $clog2(MAX_COUNT),
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_CH-1:0]    evt_in,
    input  logic [NUM_CH-1:0]    dec_in,
    input  logic [NUM_CH-1:0]    clr_in,
    output logic [NUM_CH*CW-1:0] count_out,
    output logic [NUM_CH-1:0]    wrap_out,
    input  logic                 snap_in,
    output logic                 busy_out,
    output logic                 dump_valid_out,
    input  logic                 dump_ready_in,
    output logic [IW-1:0]        dump_ch_out,
    output logic [CW-1:0]        dump_data_out
);

    localparam logic [CW:0]   TOP     = (CW+1)'(MAX_COUNT - 1);
    localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt      [NUM_CH];
    logic [CW-1:0]     cnt_nxt  [NUM_CH];
    logic [CW-1:0]     shadow   [NUM_CH];
    logic [NUM_CH-1:0] wrap_nxt;
    logic [IW-1:0]     idx;

    // Widened by one bit so the top-of-range compare is exact for any modulus.
    always_comb begin
        logic [CW:0] ext;
        logic [CW:0] ext_inc;
        logic [CW:0] ext_dec;
        ext     = '0;
        ext_inc = '0;
        ext_dec = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ext         = {1'b0, cnt[i]};
            ext_inc     = ext + 1'b1;
            ext_dec     = ext - 1'b1;
            cnt_nxt[i]  = cnt[i];
            wrap_nxt[i] = 1'b0;
            if (clr_in[i]) begin
                cnt_nxt[i] = '0;
            end else if (evt_in[i] && !dec_in[i]) begin
                if (ext == TOP) begin
                    wrap_nxt[i] = 1'b1;
                    if (SATURATE == 0) cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = ext_inc[CW-1:0];
                end
            end else if (dec_in[i] && !evt_in[i]) begin
                if (ext == '0) begin
                    wrap_nxt[i] = 1'b1;
                    if (SATURATE == 0) cnt_nxt[i] = TOP[CW-1:0];
                end else begin
                    cnt_nxt[i] = ext_dec[CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            wrap_out <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
            wrap_out <= wrap_nxt;
        end
    end

    always_comb begin
        count_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) count_out[i*CW +: CW] = cnt[i];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snap_in) state_nxt = DUMP;
            DUMP:    if (dump_ready_in && idx == LAST_CH) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow captures the pre-update counts, so a same-cycle event lands only in the live count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else if (state == IDLE) begin
            if (snap_in) begin
                idx <= '0;
                for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= cnt[i];
            end
        end else if (dump_ready_in && idx != LAST_CH) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        busy_out       = (state == DUMP);
        dump_valid_out = (state == DUMP);
        dump_ch_out    = '0;
        dump_data_out  = '0;
        if (state == DUMP) begin
            dump_ch_out   = idx;
            dump_data_out = shadow[idx];
        end
    end

endmodule

// File: tb/tb_multi_evt_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are checked against an arithmetic reference model and per-instance beat queues.
module tb_multi_evt_counter;

    localparam int NCH = 4;
    localparam int NI  = 3;   // 0: MAX 5 wrap, 1: MAX 5 saturate, 2: MAX 256 wrap

    typedef struct {
        int ch;
        int data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, snap, ready;
    logic [3:0]  evt, dec, clr;

    logic [11:0] cnt_w, cnt_s;
    logic [31:0] cnt_m;
    logic [3:0]  wrap_w, wrap_s, wrap_m;
    logic        busy_w, busy_s, busy_m;
    logic        valid_w, valid_s, valid_m;
    logic [1:0]  ch_w, ch_s, ch_m;
    logic [2:0]  data_w, data_s;
    logic [7:0]  data_m;

    int errors = 0;
    int checks = 0;

    int    m_cnt  [NI][NCH];
    bit    m_wrap [NI][NCH];
    bit    m_busy [NI];
    int    m_left [NI];
    beat_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    multi_evt_counter #(.NUM_CH(NCH), .MAX_COUNT(5), .SATURATE(0)) u_wrap (
        .clk_in(clk), .rst_in(rst), .evt_in(evt), .dec_in(dec), .clr_in(clr),
        .count_out(cnt_w), .wrap_out(wrap_w), .snap_in(snap), .busy_out(busy_w),
        .dump_valid_out(valid_w), .dump_ready_in(ready), .dump_ch_out(ch_w),
        .dump_data_out(data_w)
    );

    multi_evt_counter #(.NUM_CH(NCH), .MAX_COUNT(5), .SATURATE(1)) u_sat (
        .clk_in(clk), .rst_in(rst), .evt_in(evt), .dec_in(dec), .clr_in(clr),
        .count_out(cnt_s), .wrap_out(wrap_s), .snap_in(snap), .busy_out(busy_s),
        .dump_valid_out(valid_s), .dump_ready_in(ready), .dump_ch_out(ch_s),
        .dump_data_out(data_s)
    );

    multi_evt_counter #(.NUM_CH(NCH), .MAX_COUNT(256), .SATURATE(0)) u_main (
        .clk_in(clk), .rst_in(rst), .evt_in(evt), .dec_in(dec), .clr_in(clr),
        .count_out(cnt_m), .wrap_out(wrap_m), .snap_in(snap), .busy_out(busy_m),
        .dump_valid_out(valid_m), .dump_ready_in(ready), .dump_ch_out(ch_m),
        .dump_data_out(data_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int max_of(int k);
        return (k == 2) ? 256 : 5;
    endfunction

    function automatic logic [31:0] dut_cnt(int k, int c);
        case (k)
            0:       return 32'(cnt_w[c*3 +: 3]);
            1:       return 32'(cnt_s[c*3 +: 3]);
            default: return 32'(cnt_m[c*8 +: 8]);
        endcase
    endfunction

    function automatic logic dut_wrap(int k, int c);
        case (k)
            0:       return wrap_w[c];
            1:       return wrap_s[c];
            default: return wrap_m[c];
        endcase
    endfunction

    function automatic logic dut_busy(int k);
        case (k)
            0:       return busy_w;
            1:       return busy_s;
            default: return busy_m;
        endcase
    endfunction

    function automatic logic dut_valid(int k);
        case (k)
            0:       return valid_w;
            1:       return valid_s;
            default: return valid_m;
        endcase
    endfunction

    function automatic logic [31:0] dut_ch(int k);
        case (k)
            0:       return 32'(ch_w);
            1:       return 32'(ch_s);
            default: return 32'(ch_m);
        endcase
    endfunction

    function automatic logic [31:0] dut_data(int k);
        case (k)
            0:       return 32'(data_w);
            1:       return 32'(data_s);
            default: return 32'(data_m);
        endcase
    endfunction

    function automatic void sb_push(int k, int ch, int d);
        beat_t b;
        b.ch   = ch;
        b.data = d;
        case (k)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic int sb_size(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t sb_front(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void sb_pop(int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void sb_clear(int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Reference model: counts as plain integers, snapshot as a list of expected beats.
    function automatic void model_step();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[k][c]  = 0;
                    m_wrap[k][c] = 1'b0;
                end
                m_busy[k] = 1'b0;
                m_left[k] = 0;
                sb_clear(k);
            end else begin
                if (m_busy[k]) begin
                    if (ready) begin
                        m_left[k]--;
                        if (m_left[k] == 0) m_busy[k] = 1'b0;
                    end
                end else if (snap) begin
                    for (int c = 0; c < NCH; c++) sb_push(k, c, m_cnt[k][c]);
                    m_busy[k] = 1'b1;
                    m_left[k] = NCH;
                end
                for (int c = 0; c < NCH; c++) begin
                    int mx  = max_of(k);
                    bit sat = (k == 1);
                    int v   = m_cnt[k][c];
                    bit w   = 1'b0;
                    if (clr[c]) begin
                        v = 0;
                    end else if (evt[c] && !dec[c]) begin
                        w = (v == mx - 1);
                        v = sat ? (w ? v : v + 1) : (v + 1) % mx;
                    end else if (dec[c] && !evt[c]) begin
                        w = (v == 0);
                        v = sat ? (w ? v : v - 1) : (v + mx - 1) % mx;
                    end
                    m_cnt[k][c]  = v;
                    m_wrap[k][c] = w;
                end
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("count[%0d][%0d]", k, c), dut_cnt(k, c), 32'(m_cnt[k][c]));
                check($sformatf("wrap[%0d][%0d]", k, c), 32'(dut_wrap(k, c)), 32'(m_wrap[k][c]));
            end
            check($sformatf("busy[%0d]", k), 32'(dut_busy(k)), 32'(m_busy[k]));
            check($sformatf("valid[%0d]", k), 32'(dut_valid(k)), 32'(m_busy[k]));
            if (dut_valid(k) === 1'b1) begin
                check($sformatf("sb_has_beat[%0d]", k), 32'(sb_size(k) != 0), 32'd1);
                if (sb_size(k) != 0) begin
                    beat_t b;
                    b = sb_front(k);
                    check($sformatf("dump_ch[%0d]", k), dut_ch(k), 32'(b.ch));
                    check($sformatf("dump_data[%0d]", k), dut_data(k), 32'(b.data));
                    if (ready) sb_pop(k);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        evt  = '0;
        dec  = '0;
        clr  = '0;
        snap = 1'b0;
    endtask

    initial begin
        int exp_w [7] = '{1, 2, 3, 4, 0, 1, 2};
        int exp_s [7] = '{1, 2, 3, 4, 4, 4, 4};
        int tgt   [4] = '{7, 2, 9, 1};
        int n;

        rst   = 1'b1;
        ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_count_main", cnt_m, 32'd0);
        check("rst_wrap_main", 32'(wrap_m), 32'd0);
        check("rst_valid_main", 32'(valid_m), 32'd0);
        check("rst_busy_main", 32'(busy_m), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            evt = 4'b0001;
            tick();
            check($sformatf("wrap_seq_%0d", i), 32'(cnt_w[2:0]), 32'(exp_w[i]));
            check($sformatf("wrap_pulse_%0d", i), 32'(wrap_w[0]), 32'(i == 4));
            check($sformatf("sat_seq_%0d", i), 32'(cnt_s[2:0]), 32'(exp_s[i]));
            check($sformatf("sat_pulse_%0d", i), 32'(wrap_s[0]), 32'(i >= 4));
        end
        idle_inputs();
        clr = 4'b0001;
        tick();
        idle_inputs();
        dec = 4'b0001;
        tick();
        check("wrap_dec_at_0", 32'(cnt_w[2:0]), 32'd4);
        check("wrap_dec_pulse", 32'(wrap_w[0]), 32'd1);
        check("sat_dec_at_0", 32'(cnt_s[2:0]), 32'd0);
        check("sat_dec_pulse", 32'(wrap_s[0]), 32'd1);
        check("main_dec_at_0", 32'(cnt_m[7:0]), 32'd255);

        idle_inputs();
        clr = 4'b0010;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            evt = 4'b0010;
            tick();
        end
        clr = 4'b0010;
        tick();
        check("prio_clr_over_evt", 32'(cnt_m[15:8]), 32'd0);
        check("prio_clr_no_pulse", 32'(wrap_m[1]), 32'd0);
        clr = '0;
        for (int i = 0; i < 3; i++) tick();
        dec = 4'b0010;
        tick();
        check("prio_evt_dec_hold", 32'(cnt_m[15:8]), 32'd3);
        check("prio_evt_dec_no_pulse", 32'(wrap_m[1]), 32'd0);

        idle_inputs();
        clr = 4'b1111;
        tick();
        clr = '0;
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < NCH; c++) evt[c] = (s < tgt[c]);
            tick();
        end
        idle_inputs();
        snap = 1'b1;
        evt  = 4'b0001;
        tick();
        check("snap_live_ch0", 32'(cnt_m[7:0]), 32'd8);
        check("snap_first_data", 32'(data_m), 32'd7);
        idle_inputs();
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        snap  = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        tick();
        check("stall_ch", 32'(ch_m), 32'd2);
        check("stall_data", 32'(data_m), 32'd9);
        ready = 1'b1;
        tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        check("snap_ignored_last_beat", 32'(valid_m), 32'd0);

        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_dump_valid", 32'(valid_m), 32'd0);
        check("rst_mid_dump_count", cnt_m, 32'd0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        for (int b = 0; b < NCH; b++) begin
            check($sformatf("post_rst_beat_ch_%0d", b), 32'(ch_m), 32'(b));
            check($sformatf("post_rst_beat_data_%0d", b), 32'(data_m), 32'd0);
            tick();
        end

        for (int i = 0; i < 800; i++) begin
            evt   = 4'($urandom);
            dec   = 4'($urandom);
            clr   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            snap  = ($urandom_range(0, 7) == 0);
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end

        rst = 1'b0;
        idle_inputs();
        ready = 1'b1;
        n = 0;
        while ((busy_w || busy_s || busy_m) && n < 20) begin
            tick();
            n++;
        end
        check("drain_within_budget", 32'(n < 20), 32'd1);
        tick();
        for (int k = 0; k < NI; k++) check($sformatf("sb_empty[%0d]", k), 32'(sb_size(k)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
